// File: rtl/load_store_unit.sv
// Load/store unit: takes one byte/halfword/word request at a time, checks it,
// drives a single-beat memory access with a bounded ack wait, and reports writeback or error.
`ifndef OP_lb
`define OP_lb  6'h10
`define OP_lh  6'h11
`define OP_lw  6'h12
`define OP_lbu 6'h14
`define OP_lhu 6'h15
`define OP_sb  6'h18
`define OP_sh  6'h19
`define OP_sw  6'h1A
`endif

module load_store_unit #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk_cpu,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_op,
   input  logic [31:0] req_adrs,
   input  logic [31:0] req_data,
   input  logic [4:0]  req_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_adrs,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        done,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        err,
   output logic [1:0]  err_code
);
   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0] cnt;
   logic [5:0]    op_q;
   logic [1:0]    lane_q;
   logic [4:0]    rd_q;
   logic          load_q;

   logic          dec_load, dec_store;
   logic [1:0]    dec_size;
   logic [1:0]    dec_fault;
   logic [3:0]    dec_be;
   logic [31:0]   dec_wdata;
   logic [31:0]   ld_shift, ld_data;
   logic          accept, timeout;

   assign accept  = req_valid && (state == IDLE);
   assign timeout = (cnt == CNT_MAX);

   // dec_size: 0 byte, 1 halfword, 2 word
   always_comb begin
      dec_load  = 1'b0;
      dec_store = 1'b0;
      dec_size  = 2'd2;
      case (req_op)
         `OP_lb:  begin dec_load  = 1'b1; dec_size = 2'd0; end
         `OP_lbu: begin dec_load  = 1'b1; dec_size = 2'd0; end
         `OP_lh:  begin dec_load  = 1'b1; dec_size = 2'd1; end
         `OP_lhu: begin dec_load  = 1'b1; dec_size = 2'd1; end
         `OP_lw:  begin dec_load  = 1'b1; dec_size = 2'd2; end
         `OP_sb:  begin dec_store = 1'b1; dec_size = 2'd0; end
         `OP_sh:  begin dec_store = 1'b1; dec_size = 2'd1; end
         `OP_sw:  begin dec_store = 1'b1; dec_size = 2'd2; end
         default: ;
      endcase

      dec_fault = 2'b00;
      if (!dec_load && !dec_store)
         dec_fault = 2'b11;
      else if ((dec_size == 2'd1 && req_adrs[0]) || (dec_size == 2'd2 && req_adrs[1:0] != 2'b00))
         dec_fault = 2'b01;

      dec_be    = 4'b1111;
      dec_wdata = 32'h0;
      if (dec_store) begin
         case (dec_size)
            2'd0: begin
               dec_be    = 4'b0001 << req_adrs[1:0];
               dec_wdata = {4{req_data[7:0]}};
            end
            2'd1: begin
               dec_be    = req_adrs[1] ? 4'b1100 : 4'b0011;
               dec_wdata = {2{req_data[15:0]}};
            end
            default: dec_wdata = req_data;
         endcase
      end
   end

   // Align the addressed lane down to bit 0, then extend by load flavour
   always_comb begin
      ld_shift = mem_rdata >> {lane_q, 3'b000};
      case (op_q)
         `OP_lb:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         `OP_lbu: ld_data = {24'h0, ld_shift[7:0]};
         `OP_lh:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         `OP_lhu: ld_data = {16'h0, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = (dec_fault != 2'b00) ? DONE : ACCESS;
         ACCESS:  if (mem_ack || timeout) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_cpu or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Memory-side fields are loaded once at accept so they stay stable until ack
   always_ff @(posedge clk_cpu or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         op_q      <= 6'h0;
         lane_q    <= 2'b00;
         rd_q      <= 5'h0;
         load_q    <= 1'b0;
         mem_we    <= 1'b0;
         mem_adrs  <= 32'h0;
         mem_be    <= 4'h0;
         mem_wdata <= 32'h0;
         wb_rd     <= 5'h0;
         wb_data   <= 32'h0;
         err_code  <= 2'b00;
      end else if (accept) begin
         op_q   <= req_op;
         lane_q <= req_adrs[1:0];
         rd_q   <= req_rd;
         load_q <= dec_load;
         cnt    <= '0;
         if (dec_fault == 2'b00) begin
            mem_we    <= dec_store;
            mem_adrs  <= {req_adrs[31:2], 2'b00};
            mem_be    <= dec_be;
            mem_wdata <= dec_wdata;
         end else begin
            err_code <= dec_fault;
            wb_rd    <= req_rd;
         end
      end else if (state == ACCESS) begin
         if (mem_ack) begin
            err_code <= 2'b00;
            wb_rd    <= rd_q;
            if (load_q)
               wb_data <= ld_data;
         end else if (timeout) begin
            err_code <= 2'b10;
            wb_rd    <= rd_q;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign req_ready = (state == IDLE);
   assign mem_req   = (state == ACCESS);
   assign done      = (state == DONE);
   assign wb_en     = done && load_q && (err_code == 2'b00);
   assign err       = done && (err_code != 2'b00);

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum ACCESS cycles to wait for mem_ack before a bus error.
REQ-002 The block SHALL have port clk_cpu, input, 1 bit: single clock; all state on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit, and port req_ready, output, 1 bit: the upstream request handshake.
REQ-005 The block SHALL have port req_op, input, 6 bits: opcode, using the team's `OP_lb/lh/lw/lbu/lhu/sb/sh/sw defines.
REQ-006 The block SHALL have ports req_adrs, input, 32 bits (byte address); req_data, input, 32 bits (store data); and req_rd, input, 5 bits (load destination register).
REQ-007 The block SHALL have ports mem_req, output, 1 bit; mem_we, output, 1 bit; mem_adrs, output, 32 bits (word-aligned, [1:0]=0); mem_be, output, 4 bits; and mem_wdata, output, 32 bits.
REQ-008 The block SHALL have ports mem_rdata, input, 32 bits, and mem_ack, input, 1 bit (completes the current mem_req).
REQ-009 The block SHALL have ports done, output, 1 bit (per-request completion pulse); wb_en, output, 1 bit; wb_rd, output, 5 bits; wb_data, output, 32 bits; err, output, 1 bit; and err_code, output, 2 bits.

Function
REQ-010 The block SHALL implement FSM states IDLE, ACCESS and DONE; req_ready SHALL be 1 only in IDLE.
REQ-011 On req_valid&&req_ready the block SHALL latch op, adrs, data and rd, then move to ACCESS, or to DONE directly if the request is faulted.
REQ-012 Fault checks SHALL be: halfword op with adrs[0]=1, or word op with adrs[1:0]!=0, gives err_code 2'b01 (misalign); a non-load/store op gives 2'b11 (illegal); a faulted request SHALL never assert mem_req.
REQ-013 In ACCESS, mem_req SHALL be 1, and mem_we/mem_adrs/mem_be/mem_wdata SHALL hold stable until mem_ack is sampled 1.
REQ-014 Store lane mapping SHALL be: sb gives wdata={4{data[7:0]}}, be=4'b0001<<adrs[1:0]; sh gives wdata={2{data[15:0]}}, be=4'b0011 or 4'b1100 by adrs[1]; sw gives wdata=data, be=4'b1111.
REQ-015 For loads, mem_we SHALL be 0 and mem_be SHALL be 4'b1111.
REQ-016 On mem_ack in ACCESS for a load, the block SHALL register wb_data as mem_rdata>>(adrs[1:0]*8), sign-extended (lb/lh) or zero-extended (lbu/lhu) from bit 7 or 15; lw SHALL pass the full word; the FSM SHALL then go to DONE.
REQ-017 A cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack; if it reaches TIMEOUT, the block SHALL drop mem_req, set err_code 2'b10 and go to DONE.
REQ-018 mem_ack together with counter==TIMEOUT in the same cycle SHALL count as success.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE: done=1 for every accepted request; wb_en=1 only for an error-free load; err=1 iff err_code!=0; wb_rd SHALL equal the latched rd.
REQ-020 Outside DONE, done, wb_en and err SHALL be 0, and wb_data/wb_rd/err_code SHALL hold their last values.
REQ-021 mem_ack outside ACCESS SHALL be ignored.
REQ-022 req_valid while not ready SHALL be ignored; the requester holds it.
REQ-023 Latency SHALL be: accept at cycle N, mem_req from N+1, ack at cycle M, done at M+1; a faulted request SHALL give done at N+1.

Reset
REQ-024 With reset_n=0 the block SHALL be in IDLE, with req_ready=1, all other outputs 0 and the counter 0.
REQ-025 Assertion of reset_n mid-ACCESS SHALL drop mem_req immediately (asynchronously); the in-flight request SHALL be discarded with no done.
REQ-026 Deassertion SHALL be synchronised externally.

Verification
REQ-027 Scenario lw: req_adrs=0x100, mem_rdata=0xDEADBEEF, ack 2 cycles after mem_req -> done and wb_en=1, wb_data=0xDEADBEEF, mem_be=4'b1111.
REQ-028 Scenario lb/lbu: adrs=0x103, mem_rdata=0x80FF0000 -> lb gives wb_data=0xFFFFFF80, and lbu gives 0x00000080.
REQ-029 Scenario sh: adrs=0x202, data=0x1234ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_adrs=0x200; done with wb_en=0.
REQ-030 Scenario misalign: lw at 0x101 -> no mem_req; done, err=1, err_code=2'b01 one cycle after accept.
REQ-031 Scenario timeout: sw with ack never asserted, TIMEOUT=15 -> mem_req held 16 cycles, then done, err=1, err_code=2'b10; a later stray mem_ack is ignored.
REQ-032 Scenario reset: reset_n=0 in the second ACCESS cycle -> mem_req=0 immediately, no done; after release, req_ready=1 and a new lw completes normally.
